// File: rtl/neuron_trainer.sv
// Supervisor for a plastic neuron: drives each host sample into the neuron, waits a settle window,
// then scores the neuron output against the target and issues a learning pulse on large error.
module neuron_trainer #(
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TOLERANCE      = 16,
  parameter int unsigned CONVERGE_COUNT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_sample,
  input  logic [31:0] in_target,
  input  logic        learn_en,
  output logic [15:0] input_signal,
  input  logic [31:0] output_signal,
  output logic [15:0] feedback_error,
  output logic        enable_learning,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_error,
  output logic        res_in_tol,
  output logic        converged,
  output logic [15:0] update_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_CAPTURE,
    S_LEARN,
    S_REPORT
  } state_t;

  localparam logic [7:0]         SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]         STREAK_MAX  = 8'(CONVERGE_COUNT);
  localparam logic [16:0]        TOL_LIMIT   = 17'(TOLERANCE);
  localparam logic signed [32:0] SAT_HI      = 33'sd32767;
  localparam logic signed [32:0] SAT_LO      = -33'sd32768;

  state_t      state_q;
  logic [7:0]  settle_q;
  logic [31:0] target_q;
  logic [7:0]  streak_q;
  logic [15:0] input_signal_q;
  logic [15:0] feedback_error_q;
  logic        enable_learning_q;
  logic        res_valid_q;
  logic [15:0] res_error_q;
  logic        res_in_tol_q;
  logic        converged_q;
  logic [15:0] update_count_q;

  logic signed [32:0] diff_d;
  logic [15:0]        err_d;
  logic [16:0]        err_ext_d;
  logic [16:0]        err_abs_d;
  logic               in_tol_d;
  logic [7:0]         streak_d;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    diff_d    = $signed({target_q[31], target_q}) - $signed({output_signal[31], output_signal});
    err_d     = diff_d[15:0];
    if (diff_d > SAT_HI) begin
      err_d = 16'h7FFF;
    end else if (diff_d < SAT_LO) begin
      err_d = 16'h8000;
    end
    // 17-bit magnitude so that -32768 maps to +32768 instead of wrapping.
    err_ext_d = {err_d[15], err_d};
    err_abs_d = err_ext_d[16] ? (~err_ext_d + 17'd1) : err_ext_d;
    in_tol_d  = (err_abs_d <= TOL_LIMIT);

    streak_d = '0;
    if (res_in_tol_q) begin
      streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_IDLE;
      settle_q          <= '0;
      target_q          <= '0;
      streak_q          <= '0;
      input_signal_q    <= '0;
      feedback_error_q  <= '0;
      enable_learning_q <= 1'b0;
      res_valid_q       <= 1'b0;
      res_error_q       <= '0;
      res_in_tol_q      <= 1'b0;
      converged_q       <= 1'b0;
      update_count_q    <= '0;
    end else begin
      enable_learning_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            input_signal_q <= in_sample;
            target_q       <= in_target;
            settle_q       <= '0;
            state_q        <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          settle_q <= settle_q + 8'd1;
          if (settle_q == SETTLE_LAST) begin
            state_q <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          feedback_error_q  <= err_d;
          res_error_q       <= err_d;
          res_in_tol_q      <= in_tol_d;
          enable_learning_q <= !in_tol_d && learn_en;
          state_q           <= S_LEARN;
        end
        S_LEARN: begin
          if (enable_learning_q && (update_count_q != 16'hFFFF)) begin
            update_count_q <= update_count_q + 16'd1;
          end
          streak_q    <= streak_d;
          converged_q <= (streak_d == STREAK_MAX);
          res_valid_q <= 1'b1;
          state_q     <= S_REPORT;
        end
        S_REPORT: begin
          // Result is held until the host takes it; a new sample waits for IDLE.
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready        = (state_q == S_IDLE);
  assign input_signal    = input_signal_q;
  assign feedback_error  = feedback_error_q;
  assign enable_learning = enable_learning_q;
  assign res_valid       = res_valid_q;
  assign res_error       = res_error_q;
  assign res_in_tol      = res_in_tol_q;
  assign converged       = converged_q;
  assign update_count    = update_count_q;

endmodule

// File: tb/tb_neuron_trainer.sv
// Bench for neuron_trainer: a stand-in plastic neuron, a transaction-level reference model
// compared every cycle, and directed samples with hand-computed results.
module tb_neuron_trainer;

  localparam int SETTLE = 2;
  localparam int TOL    = 16;
  localparam int CONV   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_sample;
  logic [31:0] in_target;
  logic        learn_en;
  logic [15:0] input_signal;
  logic [31:0] output_signal;
  logic [15:0] feedback_error;
  logic        enable_learning;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_error;
  logic        res_in_tol;
  logic        converged;
  logic [15:0] update_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  neuron_trainer #(
    .SETTLE_CYCLES (SETTLE),
    .TOLERANCE     (TOL),
    .CONVERGE_COUNT(CONV)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sample      (in_sample),
    .in_target      (in_target),
    .learn_en       (learn_en),
    .input_signal   (input_signal),
    .output_signal  (output_signal),
    .feedback_error (feedback_error),
    .enable_learning(enable_learning),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_error      (res_error),
    .res_in_tol     (res_in_tol),
    .converged      (converged),
    .update_count   (update_count)
  );

  // Stand-in neuron: output = input - weight, reset weight 1070; the learning step err/176
  // reproduces the reference neuron's 1070 -> 1093 move for an error of 4070.
  int nrn_weight;
  assign output_signal = 32'({16'b0, input_signal}) - 32'(nrn_weight);
  always @(posedge clk) begin
    if (rst) nrn_weight <= 1070;
    else if (enable_learning) nrn_weight <= nrn_weight + int'($signed(feedback_error)) / 176;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction timing + plain arithmetic) ----------------
  function automatic logic [15:0] sat_err(input int tgt, input int out);
    longint d;
    d = longint'(tgt) - longint'(out);
    if (d > 32767) return 16'h7FFF;
    if (d < -32768) return 16'h8000;
    return 16'(d);
  endfunction

  function automatic logic within_tol(input logic [15:0] e);
    int v;
    v = int'($signed(e));
    if (v < 0) v = -v;
    return v <= TOL;
  endfunction

  function automatic int next_streak(input int s, input logic tol);
    if (!tol) return 0;
    return (s >= CONV) ? CONV : s + 1;
  endfunction

  bit          live = 0;
  int          m_now = 0;
  int          cap_at, rep_at;
  bit          m_busy, m_pend;
  int          m_weight, m_streak;
  logic [31:0] m_tgt;
  logic [15:0] e_input, e_fb, e_rerr, e_upd;
  logic        e_pulse, e_rv, e_tol, e_conv;

  always @(posedge clk) begin
    m_now <= m_now + 1;
    if (rst) begin
      live <= 1; m_busy <= 0; m_pend <= 0; m_streak <= 0; m_weight <= 1070;
      e_input <= 0; e_fb <= 0; e_rerr <= 0; e_upd <= 0;
      e_pulse <= 0; e_rv <= 0; e_tol <= 0; e_conv <= 0;
    end else if (m_pend) begin
      if (res_ready) begin
        m_pend <= 0; m_busy <= 0; e_rv <= 0;
      end
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy  <= 1;
        e_input <= in_sample;
        m_tgt   <= in_target;
        cap_at  <= m_now + SETTLE + 1;
        rep_at  <= m_now + SETTLE + 2;
      end
    end else if (m_now == cap_at) begin
      e_fb    <= sat_err(int'(m_tgt), int'({16'b0, e_input}) - m_weight);
      e_rerr  <= sat_err(int'(m_tgt), int'({16'b0, e_input}) - m_weight);
      e_tol   <= within_tol(sat_err(int'(m_tgt), int'({16'b0, e_input}) - m_weight));
      e_pulse <= !within_tol(sat_err(int'(m_tgt), int'({16'b0, e_input}) - m_weight)) && learn_en;
    end else if (m_now == rep_at) begin
      e_pulse <= 0;
      e_rv    <= 1;
      m_pend  <= 1;
      if (e_pulse) begin
        e_upd    <= (e_upd == 16'hFFFF) ? e_upd : e_upd + 16'd1;
        m_weight <= m_weight + int'($signed(e_fb)) / 176;
      end
      m_streak <= next_streak(m_streak, e_tol);
      e_conv   <= (next_streak(m_streak, e_tol) == CONV);
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("in_ready",        64'(in_ready),        64'(!m_busy));
      check("input_signal",    64'(input_signal),    64'(e_input));
      check("feedback_error",  64'(feedback_error),  64'(e_fb));
      check("enable_learning", 64'(enable_learning), 64'(e_pulse));
      check("res_valid",       64'(res_valid),       64'(e_rv));
      check("res_error",       64'(res_error),       64'(e_rerr));
      check("res_in_tol",      64'(res_in_tol),      64'(e_tol));
      check("converged",       64'(converged),       64'(e_conv));
      check("update_count",    64'(update_count),    64'(e_upd));
    end
  end

  int          pulse_total = 0;
  logic [15:0] fb_at_pulse = 0;
  always @(negedge clk) begin
    if (enable_learning) begin
      pulse_total <= pulse_total + 1;
      fb_at_pulse <= feedback_error;
    end
  end

  // ---------------- directed stimulus ----------------
  // Called at a falling edge; returns at the falling edge where res_valid is first seen.
  task automatic send(input logic [15:0] s, input logic [31:0] t, input logic rr,
                      output int lat, output int npulse);
    int n;
    int p0;
    p0 = pulse_total;
    in_valid = 1; in_sample = s; in_target = t;
    n = 0;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    check("accept_within_bound", 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid  = 0;
    res_ready = rr;
    lat = 0;
    while (!res_valid && lat < 40) begin @(negedge clk); lat++; end
    check("result_within_bound", 64'(res_valid), 64'(1));
    npulse = pulse_total - p0;
  endtask

  logic [15:0] conv_samp [4] = '{16'd1000, 16'd2000, 16'd3000, 16'd50};
  logic [31:0] conv_tgt  [4] = '{-32'sd116, 32'sd884, 32'sd1884, -32'sd1066};

  initial begin
    int lat, np, p0;
    rst = 1; in_valid = 0; in_sample = 0; in_target = 0; learn_en = 1; res_ready = 1;
    repeat (2) @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_update_count", 64'(update_count), 64'(0));
    rst = 0;
    @(negedge clk);

    // Zero error, latency 4
    send(16'd100, -32'sd970, 1'b1, lat, np);
    check("t1_latency", 64'(lat), 64'(4));
    check("t1_res_error", 64'(res_error), 64'(16'd0));
    check("t1_in_tol", 64'(res_in_tol), 64'(1));
    check("t1_no_pulse", 64'(np), 64'(0));
    check("t1_update_count", 64'(update_count), 64'(0));

    // Learning pulse, then repeated sample after the weight moved
    send(16'd2000, 32'sd5000, 1'b1, lat, np);
    check("t2_res_error", 64'(res_error), 64'(16'd4070));
    check("t2_in_tol", 64'(res_in_tol), 64'(0));
    check("t2_one_pulse", 64'(np), 64'(1));
    check("t2_fb_at_pulse", 64'(fb_at_pulse), 64'(16'd4070));
    check("t2_update_count", 64'(update_count), 64'(1));
    send(16'd2000, 32'sd5000, 1'b1, lat, np);
    check("t2b_res_error_out907", 64'(res_error), 64'(16'd4093));
    check("t2b_update_count", 64'(update_count), 64'(2));

    // Saturation both ways
    send(16'd0, 32'h7FFFFFFF, 1'b1, lat, np);
    check("t3_pos_sat", 64'(res_error), 64'(16'h7FFF));
    send(16'd0, 32'h80000000, 1'b1, lat, np);
    check("t3_neg_sat", 64'(res_error), 64'(16'h8000));
    check("t3_neg_in_tol", 64'(res_in_tol), 64'(0));
    check("t3_update_count", 64'(update_count), 64'(4));

    // Convergence streak (weight is back to 1116 here)
    for (int i = 0; i < 4; i++) begin
      send(conv_samp[i], conv_tgt[i], 1'b1, lat, np);
      check("t4_err_zero", 64'(res_error), 64'(16'd0));
      check("t4_converged", 64'(converged), 64'(i == 3));
    end
    send(16'd1000, 32'sd384, 1'b1, lat, np);
    check("t4_err500", 64'(res_error), 64'(16'd500));
    check("t4_converged_drop", 64'(converged), 64'(0));

    // Backpressure: result held, no accept (weight now 1118)
    send(16'd1200, 32'sd82, 1'b0, lat, np);
    in_valid = 1; in_sample = 16'd7; in_target = 32'd7;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_hold_valid", 64'(res_valid), 64'(1));
      check("t5_hold_err", 64'(res_error), 64'(16'd0));
      check("t5_hold_tol", 64'(res_in_tol), 64'(1));
      check("t5_hold_ready", 64'(in_ready), 64'(0));
    end
    in_valid = 0;
    res_ready = 1;
    @(negedge clk);
    check("t5_released_valid", 64'(res_valid), 64'(0));
    check("t5_released_ready", 64'(in_ready), 64'(1));

    // learn_en gate
    learn_en = 0;
    send(16'd2000, 32'sd4952, 1'b1, lat, np);
    check("t5_gated_err", 64'(res_error), 64'(16'd4070));
    check("t5_gated_tol", 64'(res_in_tol), 64'(0));
    check("t5_gated_no_pulse", 64'(np), 64'(0));
    check("t5_gated_count", 64'(update_count), 64'(5));
    learn_en = 1;

    // Reset one cycle after accept aborts the sample
    p0 = pulse_total;
    in_valid = 1; in_sample = 16'd300; in_target = 32'd0;
    for (int n = 0; n < 40 && !in_ready; n++) @(negedge clk);
    @(negedge clk);
    in_valid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("t6_input_signal", 64'(input_signal), 64'(0));
    check("t6_feedback_error", 64'(feedback_error), 64'(0));
    check("t6_res_error", 64'(res_error), 64'(0));
    check("t6_update_count", 64'(update_count), 64'(0));
    check("t6_converged", 64'(converged), 64'(0));
    check("t6_in_ready", 64'(in_ready), 64'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t6_no_result", 64'(res_valid), 64'(0));
    end
    check("t6_no_pulse", 64'(pulse_total - p0), 64'(0));

    // Normal operation after reset, neuron weight back to 1070
    send(16'd100, -32'sd970, 1'b1, lat, np);
    check("t7_latency", 64'(lat), 64'(4));
    check("t7_res_error", 64'(res_error), 64'(16'd0));
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
